// File: rtl/debug_scan_ctrl.sv
// debug_scan_ctrl: walks every debug-mux source (lo byte, then hi byte) and streams the sampled bytes out.
// Latency: start to first tx_valid is SETTLE+1 cycles; at least one idle cycle between bytes.
// Backpressure: the byte on tx_data is held with mux select stable until tx_valid && tx_ready.
// Optional: define DEBUG_SCAN_CSUM_EN to append an 8-bit mod-256 sum byte to every frame.
module debug_scan_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3,
  parameter int SETTLE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  output logic [SEL_W-1:0] dbg_sel,
  output logic             dbg_high,
  input  logic [7:0]       dbg_byte,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             frame_done
);

  localparam int                 IDX_W       = SEL_W + 1;
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(2 * NUM_SRC - 1);
  localparam int                 CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SEND,
`ifdef DEBUG_SCAN_CSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] settle_cnt;
`ifdef DEBUG_SCAN_CSUM_EN
  logic [7:0]       sum;
`endif

  // Byte index k maps to source k>>1, half k[0].
  assign idx_nxt = idx + IDX_W'(1);

  // Scan sequencer: all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      dbg_sel    <= '0;
      dbg_high   <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef DEBUG_SCAN_CSUM_EN
      sum        <= 8'h00;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SETUP;
            busy       <= 1'b1;
            idx        <= '0;
            settle_cnt <= '0;
            dbg_sel    <= '0;
            dbg_high   <= 1'b0;
`ifdef DEBUG_SCAN_CSUM_EN
            sum        <= 8'h00;
`endif
          end
        end

        // Hold the select for SETTLE cycles, then capture the mux byte.
        S_SETUP: begin
          if (settle_cnt == SETTLE_LAST) begin
            tx_data  <= dbg_byte;
            tx_valid <= 1'b1;
            state    <= S_SEND;
`ifdef DEBUG_SCAN_CSUM_EN
            sum      <= sum + dbg_byte;
`endif
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end

        S_SEND: begin
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            if (idx != LAST_IDX) begin
              idx        <= idx_nxt;
              dbg_sel    <= idx_nxt[SEL_W:1];
              dbg_high   <= idx_nxt[0];
              settle_cnt <= '0;
              state      <= S_SETUP;
            end else begin
`ifdef DEBUG_SCAN_CSUM_EN
              state      <= S_CSUM;
`else
              state      <= S_DONE;
              frame_done <= 1'b1;
`endif
            end
          end
        end

`ifdef DEBUG_SCAN_CSUM_EN
        // First cycle presents the sum (tx_valid was dropped by the last handshake).
        S_CSUM: begin
          if (!tx_valid) begin
            tx_data  <= sum;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            tx_valid   <= 1'b0;
            state      <= S_DONE;
            frame_done <= 1'b1;
          end
        end
`endif

        // frame_done is high for this single cycle; continuous decides restart.
        S_DONE: begin
          if (continuous) begin
            state      <= S_SETUP;
            idx        <= '0;
            settle_cnt <= '0;
            dbg_sel    <= '0;
            dbg_high   <= 1'b0;
`ifdef DEBUG_SCAN_CSUM_EN
            sum        <= 8'h00;
`endif
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// Bench for debug_scan_ctrl: scoreboard of expected bytes, popped on each accepted handshake.
// Covers reset, frame order, stall, ignored start, continuous mode, async reset mid-frame, checksum when enabled.
// Mux sources are modelled here as a 16-bit register array.
module tb_debug_scan_ctrl;

  localparam int NUM_SRC = 8;
  localparam int SEL_W   = 3;
`ifdef DEBUG_SCAN_CSUM_EN
  localparam int FB = 2 * NUM_SRC + 1;
`else
  localparam int FB = 2 * NUM_SRC;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             continuous;
  logic [SEL_W-1:0] dbg_sel;
  logic             dbg_high;
  logic [7:0]       dbg_byte;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             frame_done;

  logic [15:0] src [NUM_SRC];
  logic [7:0]  exp_q [$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          nbytes   = 0;
  int          fd_count = 0;

  debug_scan_ctrl #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .SETTLE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .continuous (continuous),
    .dbg_sel    (dbg_sel),
    .dbg_high   (dbg_high),
    .dbg_byte   (dbg_byte),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    dbg_byte = dbg_high ? src[dbg_sel][15:8] : src[dbg_sel][7:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected bytes of one frame from the current source values.
  task automatic push_frame();
    logic [7:0] b;
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 2 * NUM_SRC; k++) begin
      b = (k % 2 == 1) ? src[k / 2][15:8] : src[k / 2][7:0];
      exp_q.push_back(b);
      s = s + b;
    end
`ifdef DEBUG_SCAN_CSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  // Monitor: an accepted byte is seen here before the edge that completes it.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      nbytes++;
      if (exp_q.size() == 0) chk("extra_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else chk("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
    end
    if (rst_n && frame_done) begin
      fd_count++;
      chk("fd_at_frame_end", nbytes % FB, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!tx_valid && n < 50) begin
      tick();
      n++;
    end
    if (!tx_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_fd(input int target, input int bound);
    int n = 0;
    while (fd_count < target && n < bound) begin
      tick();
      n++;
    end
    chk("fd_reached", fd_count >= target, 1);
  endtask

  task automatic wait_bytes(input int target, input int bound);
    int n = 0;
    while (nbytes < target && n < bound) begin
      tick();
      n++;
    end
    chk("bytes_reached", nbytes >= target, 1);
  endtask

  // Keeps ready high and checks nothing more is offered while idle.
  task automatic check_quiet(input string tag, input int cycles);
    logic saw;
    saw = 1'b0;
    tx_ready = 1'b1;
    repeat (cycles) begin
      tick();
      if (tx_valid || busy) saw = 1'b1;
    end
    chk(tag, saw, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_base;
    logic ok;
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) src[i] = 16'h1100 + 16'(i) * 16'h0101;

    // Reset state
    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dbg_sel", dbg_sel, 0);
    chk("rst_dbg_high", dbg_high, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    tick();

    // 1: plain frame with ready always high, latency SETTLE+1
    tx_ready = 1'b1;
    push_frame();
    pulse_start();
    chk("t1_busy_setup", busy, 1);
    chk("t1_valid_setup", tx_valid, 0);
    tick();
    chk("t1_first_valid", tx_valid, 1);
    chk("t1_first_sel", {dbg_sel, dbg_high}, 0);
    wait_fd(1, 200);
    tick(); tick();
    chk("t1_busy_low", busy, 0);
    chk("t1_bytes", nbytes, FB);
    chk("t1_q_empty", exp_q.size(), 0);
    chk("t1_fd_once", fd_count, 1);

    // 2+3: stall on byte 3 for 20 cycles, start pulsed at byte 5
    tx_ready = 1'b0;
    nbytes = 0;
    fd_base = fd_count;
    push_frame();
    pulse_start();
    for (int b = 0; b < FB; b++) begin
      wait_valid();
      if (b == 3) begin
        ok = 1'b1;
        repeat (20) begin
          if (!(tx_valid && tx_data == 8'h12 && dbg_sel == 3'd1 && dbg_high)) ok = 1'b0;
          tick();
        end
        chk("t2_stall_stable", ok, 1);
        chk("t2_stall_data", tx_data, 8'h12);
      end
      if (b == 5) start = 1'b1;
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      start = 1'b0;
    end
    wait_fd(fd_base + 1, 100);
    check_quiet("t3_no_restart", 15);
    chk("t3_fd_once", fd_count, fd_base + 1);
    chk("t3_bytes", nbytes, FB);

    // 4: continuous runs a second frame, dropped during frame 2
    nbytes = 0;
    fd_base = fd_count;
    push_frame();
    push_frame();
    continuous = 1'b1;
    tx_ready = 1'b1;
    pulse_start();
    wait_bytes(FB + 4, 400);
    continuous = 1'b0;
    wait_fd(fd_base + 2, 400);
    check_quiet("t4_idle_after", 10);
    chk("t4_bytes", nbytes, 2 * FB);
    chk("t4_fd_count", fd_count, fd_base + 2);
    chk("t4_q_empty", exp_q.size(), 0);

    // 5: async reset while a byte is waiting in SEND
    nbytes = 0;
    push_frame();
    pulse_start();
    wait_bytes(5, 200);
    tx_ready = 1'b0;
    wait_valid();
    chk("t5_sel_before", dbg_sel, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", tx_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_sel", dbg_sel, 0);
    exp_q.delete();
    nbytes = 0;
    tick();
    rst_n = 1'b1;
    check_quiet("t5_quiet_after_rst", 20);
    chk("t5_no_bytes", nbytes, 0);

    // 6: uniform sources (checksum byte 0x10 when enabled)
    for (int i = 0; i < NUM_SRC; i++) src[i] = 16'h0101;
    nbytes = 0;
    fd_base = fd_count;
    push_frame();
    pulse_start();
    wait_fd(fd_base + 1, 300);
    chk("t6_bytes", nbytes, FB);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
